// File: rtl/vga_sync_if.sv
// Timing bundle from vga_sync_gen to the pixel stage.
// frame_count is present only when VGA_SYNC_FRAME_CNT_EN is defined.
interface vga_sync_if;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       p_tick;
   logic       frame_start;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] frame_count;
`endif

   modport master (
`ifdef VGA_SYNC_FRAME_CNT_EN
      output frame_count,
`endif
      output hsync, vsync, video_on, p_tick, frame_start, pixel_x, pixel_y
   );

   modport slave (
`ifdef VGA_SYNC_FRAME_CNT_EN
      input frame_count,
`endif
      input hsync, vsync, video_on, p_tick, frame_start, pixel_x, pixel_y
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters, sync and blanking decode.
// Optional 8-bit frame counter enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input logic        clk,
   input logic        reset_n,
   vga_sync_if.master vga
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0]       HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0]       HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]       VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0]       VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_count;
   logic             p_tick;
   logic             frame_start;
   logic             hsync;
   logic             vsync;
   logic [9:0]       h_count;
   logic [9:0]       v_count;
   logic [9:0]       h_next;
   logic [9:0]       v_next;
   logic             h_wrap;
   logic             v_wrap;

   always_comb begin
      // NOTE: every output gets a default before the conditions, so no path leaves one unassigned (no latch).
      h_wrap = (h_count == H_MAX);
      v_wrap = (v_count == V_MAX);
      h_next = h_count;
      v_next = v_count;
      if (p_tick) begin
         h_next = h_wrap ? '0 : h_count + 10'd1;
         if (h_wrap) begin
            v_next = v_wrap ? '0 : v_count + 10'd1;
         end
      end
   end

   // Syncs are decoded from the next counter values so they land on the same edge as pixel_x/pixel_y.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         div_count   <= '0;
         p_tick      <= 1'b0;
         h_count     <= '0;
         v_count     <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         if (div_count == DIV_MAX) begin
            div_count <= '0;
            p_tick    <= 1'b1;
         end else begin
            div_count <= div_count + DIV_W'(1);
            p_tick    <= 1'b0;
         end
         h_count     <= h_next;
         v_count     <= v_next;
         hsync       <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
         vsync       <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
         frame_start <= p_tick && h_wrap && v_wrap;
      end
   end

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] frame_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_count <= '0;
      end else if (p_tick && h_wrap && v_wrap) begin
         frame_count <= frame_count + 8'd1;
      end
   end

   assign vga.frame_count = frame_count;
`endif

   assign vga.hsync       = hsync;
   assign vga.vsync       = vsync;
   assign vga.video_on    = (h_count < H_VIS) && (v_count < V_VIS);
   assign vga.p_tick      = p_tick;
   assign vga.frame_start = frame_start;
   assign vga.pixel_x     = h_count;
   assign vga.pixel_y     = v_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations checked every cycle against an arithmetic model,
// plus a line-timing vector table and directed reset / frame-wrap sequences.
module tb_vga_sync_gen;

   typedef struct packed {
      int unsigned div;
      int unsigned hd, hf, hs, hb;
      int unsigned vd, vf, vs, vb;
   } cfg_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       pt;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   typedef struct {
      int unsigned k;
      obs_t        exp;
   } vec_t;

   // A: default 640x480 timing; B: default line, short frame; C: tiny timing, one clk per pixel.
   localparam cfg_t CFG_A = '{div: 2, hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33};
   localparam cfg_t CFG_B = '{div: 2, hd: 640, hf: 16, hs: 96, hb: 48, vd: 4,   vf: 1,  vs: 2, vb: 1};
   localparam cfg_t CFG_C = '{div: 1, hd: 8,   hf: 2,  hs: 2,  hb: 2,  vd: 4,   vf: 1,  vs: 1, vb: 1};

   localparam obs_t RESET_OBS = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b1, pt: 1'b0, fs: 1'b0, fc: 8'd0};

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   logic rst_c = 1'b0;
   logic mon_en = 1'b0;
   int unsigned k_a = 0;
   int unsigned k_b = 0;
   int unsigned k_c = 0;
   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   vga_sync_if if_a ();
   vga_sync_if if_b ();
   vga_sync_if if_c ();

   vga_sync_gen #(
      .CLK_DIV(CFG_A.div), .H_DISPLAY(CFG_A.hd), .H_FRONT(CFG_A.hf), .H_SYNC(CFG_A.hs), .H_BACK(CFG_A.hb),
      .V_DISPLAY(CFG_A.vd), .V_FRONT(CFG_A.vf), .V_SYNC(CFG_A.vs), .V_BACK(CFG_A.vb)
   ) dut_a (.clk(clk), .reset_n(rst_a), .vga(if_a));

   vga_sync_gen #(
      .CLK_DIV(CFG_B.div), .H_DISPLAY(CFG_B.hd), .H_FRONT(CFG_B.hf), .H_SYNC(CFG_B.hs), .H_BACK(CFG_B.hb),
      .V_DISPLAY(CFG_B.vd), .V_FRONT(CFG_B.vf), .V_SYNC(CFG_B.vs), .V_BACK(CFG_B.vb)
   ) dut_b (.clk(clk), .reset_n(rst_b), .vga(if_b));

   vga_sync_gen #(
      .CLK_DIV(CFG_C.div), .H_DISPLAY(CFG_C.hd), .H_FRONT(CFG_C.hf), .H_SYNC(CFG_C.hs), .H_BACK(CFG_C.hb),
      .V_DISPLAY(CFG_C.vd), .V_FRONT(CFG_C.vf), .V_SYNC(CFG_C.vs), .V_BACK(CFG_C.vb)
   ) dut_c (.clk(clk), .reset_n(rst_c), .vga(if_c));

   logic [7:0] fc_a, fc_b, fc_c;
`ifdef VGA_SYNC_FRAME_CNT_EN
   assign fc_a = if_a.frame_count;
   assign fc_b = if_b.frame_count;
   assign fc_c = if_c.frame_count;
`else
   assign fc_a = 8'h00;
   assign fc_b = 8'h00;
   assign fc_c = 8'h00;
`endif

   obs_t obs_a, obs_b, obs_c;
   assign obs_a = {if_a.pixel_x, if_a.pixel_y, if_a.hsync, if_a.vsync, if_a.video_on, if_a.p_tick, if_a.frame_start, fc_a};
   assign obs_b = {if_b.pixel_x, if_b.pixel_y, if_b.hsync, if_b.vsync, if_b.video_on, if_b.p_tick, if_b.frame_start, fc_b};
   assign obs_c = {if_c.pixel_x, if_c.pixel_y, if_c.hsync, if_c.vsync, if_c.video_on, if_c.p_tick, if_c.frame_start, fc_c};

   // Clock edges seen with reset released since the last reset edge.
   always @(posedge clk) begin
      k_a <= rst_a ? k_a + 1 : 0;
      k_b <= rst_b ? k_b + 1 : 0;
      k_c <= rst_c ? k_c + 1 : 0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs after k released edges: p_tick on every div-th edge, one pixel per
   // p_tick seen on the following edge, coordinates and decodes from the pixel count.
   function automatic obs_t model(input cfg_t c, input int unsigned k);
      obs_t        o;
      int unsigned ht, vt, fr, n, n_prev, x, y;
      ht     = c.hd + c.hf + c.hs + c.hb;
      vt     = c.vd + c.vf + c.vs + c.vb;
      fr     = ht * vt;
      n      = (k == 0) ? 0 : (k - 1) / c.div;
      n_prev = (k < 2) ? 0 : (k - 2) / c.div;
      x      = n % ht;
      y      = (n / ht) % vt;
      o.x    = 10'(x);
      o.y    = 10'(y);
      o.hs   = !((x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs));
      o.vs   = !((y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs));
      o.vo   = (x < c.hd) && (y < c.vd);
      o.pt   = (k != 0) && (k % c.div == 0);
      o.fs   = (n != n_prev) && (n % fr == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
      o.fc   = 8'((n / fr) % 256);
`else
      o.fc   = 8'd0;
`endif
      return o;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         check("model_a", obs_a, model(CFG_A, k_a));
         check("model_b", obs_b, model(CFG_B, k_b));
         check("model_c", obs_c, model(CFG_C, k_c));
      end
   end

   function automatic vec_t mk(input int unsigned k, input int x, input int y,
                               input logic hs, input logic vo, input logic pt);
      vec_t v;
      v.k   = k;
      v.exp = '{x: 10'(x), y: 10'(y), hs: hs, vs: 1'b1, vo: vo, pt: pt, fs: 1'b0, fc: 8'd0};
      return v;
   endfunction

   // Line timing on the default configuration, indexed by released edges.
   task automatic run_a();
      vec_t vecs[13];
      vecs[0]  = mk(1,    0,   0, 1'b1, 1'b1, 1'b0);
      vecs[1]  = mk(2,    0,   0, 1'b1, 1'b1, 1'b1);
      vecs[2]  = mk(3,    1,   0, 1'b1, 1'b1, 1'b0);
      vecs[3]  = mk(1279, 639, 0, 1'b1, 1'b1, 1'b0);
      vecs[4]  = mk(1281, 640, 0, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1311, 655, 0, 1'b1, 1'b0, 1'b0);
      vecs[6]  = mk(1313, 656, 0, 1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(1314, 656, 0, 1'b0, 1'b0, 1'b1);
      vecs[8]  = mk(1503, 751, 0, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(1505, 752, 0, 1'b1, 1'b0, 1'b0);
      vecs[10] = mk(1599, 799, 0, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1601, 0,   1, 1'b1, 1'b1, 1'b0);
      vecs[12] = mk(1602, 0,   1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 13; i++) begin
         while (k_a < vecs[i].k) @(negedge clk);
         check($sformatf("line_vec[%0d]", i), obs_a, vecs[i].exp);
      end
   endtask

   task automatic wait_fs_b(input string name, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (obs_b.fs !== 1'b1 && cyc < 20000);
      if (obs_b.fs !== 1'b1) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   // Mid-frame reset, then frame period and pulse width on the short-frame configuration.
   task automatic run_b();
      int gap;
      int period;
      period = int'(CFG_B.div * (CFG_B.hd + CFG_B.hf + CFG_B.hs + CFG_B.hb) *
                    (CFG_B.vd + CFG_B.vf + CFG_B.vs + CFG_B.vb));
      while (k_b < 4601) @(negedge clk);  // first edge showing x=700, y=2
      check("mid_pre_xy", {obs_b.x, obs_b.y}, {10'd700, 10'd2});
      rst_b = 1'b0;
      @(negedge clk);
      check("mid_reset", obs_b, RESET_OBS);
      rst_b = 1'b1;
      @(negedge clk);
      check("mid_rel_e1", {obs_b.pt, obs_b.x}, {1'b0, 10'd0});
      @(negedge clk);
      check("mid_rel_e2", {obs_b.pt, obs_b.x}, {1'b1, 10'd0});
      @(negedge clk);
      check("mid_rel_e3", {obs_b.pt, obs_b.x}, {1'b0, 10'd1});
      wait_fs_b("fs_b_first", gap);
      check("fs_b_xy", {obs_b.x, obs_b.y, obs_b.vs}, {10'd0, 10'd0, 1'b1});
      @(negedge clk);
      check("fs_b_width", obs_b.fs, 1'b0);
      wait_fs_b("fs_b_second", gap);
      check("frame_period", gap + 1, period);
   endtask

   // Random resets, then 256 frames to exercise the simultaneous wrap and frame_count wrap.
   task automatic run_c();
      int   cyc;
      obs_t prev;
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(150, 1)) @(negedge clk);
         rst_c = 1'b0;
         repeat ($urandom_range(3, 1)) @(negedge clk);
         rst_c = 1'b1;
      end
      rst_c = 1'b0;
      @(negedge clk);
      rst_c = 1'b1;
      prev = obs_c;
      for (int f = 1; f <= 256; f++) begin
         cyc = 0;
         do begin
            prev = obs_c;
            @(negedge clk);
            cyc++;
         end while (obs_c.fs !== 1'b1 && cyc < 200);
         if (obs_c.fs !== 1'b1) begin
            check("fs_c_timeout", 64'd0, 64'd1);
            break;
         end
         check("wrap_c_xy", {obs_c.x, obs_c.y}, 20'd0);
         if (f == 1) check("wrap_c_prev_xy", {prev.x, prev.y}, {10'd13, 10'd6});
`ifdef VGA_SYNC_FRAME_CNT_EN
         if (f >= 255) check("frame_count", obs_c.fc, 8'(f % 256));
`endif
         @(negedge clk);
         check("fs_c_width", obs_c.fs, 1'b0);
      end
   endtask

   initial begin
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         mon_en = 1'b1;
         check($sformatf("reset_hold[%0d]", i), obs_a, RESET_OBS);
      end
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      fork
         run_a();
         run_b();
         run_c();
      join
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator directly upstream of the pixel generation stage.
- Divides the system clock into a pixel-rate enable and runs horizontal/vertical counters.
- Produces hsync, vsync, video_on and the pixel_x/pixel_y coordinates that the pixel stage consumes.
- Default timing is 640x480@60 Hz: 800 x 525 total, 25 MHz pixel rate from a 50 MHz clk.

Parameters:
- CLK_DIV, 2, system clocks per pixel; legal range >= 1.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- Derived: H_TOTAL = sum of the four H_* values; V_TOTAL = sum of the four V_* values.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- reset_n  input  1  synchronous, active-low reset.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- video_on  output  1  high while (pixel_x, pixel_y) is in the visible area.
- p_tick  output  1  one-clk pulse marking each pixel advance.
- frame_start  output  1  one-clk pulse when the counters wrap to (0,0).
- pixel_x  output  10  current column, equal to h_count.
- pixel_y  output  10  current row, equal to v_count.

Behaviour:
- Reset: one clk and reset are already decided; reset is synchronous, active-low, sampled on rising clk when reset_n = 0. It overrides all other activity, including mid-frame.
- Reset values:
  - div_count = 0, h_count = 0, v_count = 0.
  - p_tick = 0, frame_start = 0.
  - hsync = 1, vsync = 1.
  - video_on = 1, since (0,0) is visible.
- Divider:
  - div_count counts 0..CLK_DIV-1 and wraps.
  - p_tick is registered: it is 1 in the cycle after div_count reaches CLK_DIV-1.
  - With default CLK_DIV = 2, p_tick is high on every second clk.
  - With CLK_DIV = 1, p_tick is constantly 1 after the first post-reset cycle.
- Counters: they advance only on clk edges where p_tick = 1.
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - v_count increments only on an h_count wrap; at V_TOTAL-1 it wraps to 0.
  - Simultaneous wrap (h = H_TOTAL-1 and v = V_TOTAL-1): both go to 0 on the same edge.
- Sync outputs: hsync and vsync are registered from the next counter values, so they change on the same edge as the counters they describe (zero skew versus pixel_x/pixel_y).
  - hsync = 0 exactly when H_DISPLAY+H_FRONT <= h_count <= H_DISPLAY+H_FRONT+H_SYNC-1. Default: h in 656..751.
  - vsync = 0 exactly when V_DISPLAY+V_FRONT <= v_count <= V_DISPLAY+V_FRONT+V_SYNC-1. Default: v in 490..491.
- video_on = (h_count < H_DISPLAY) && (v_count < V_DISPLAY). It is decoded from the counter registers and introduces no extra latency.
- frame_start: registered, high for exactly one clk on the edge where both counters wrap to 0. It is not asserted by reset.
- Widths and timing:
  - Counters are 10 bits; H_TOTAL and V_TOTAL must be <= 1024.
  - Pixel period = CLK_DIV clks; line = H_TOTAL pixels; frame = H_TOTAL*V_TOTAL pixels (420000 at default).

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_count, 8 bits.
  - Reset value 0; increments on every frame_start edge; wraps 255 -> 0.
  - Intended for animation in downstream pixel logic.
- When undefined: the port and register are absent, and all other behaviour is identical.

Test Plan:
- Reset release: hold reset_n = 0 for 5 clks, then release.
  - During reset: hsync = vsync = 1, video_on = 1, x = y = 0.
  - First p_tick at clk 2 after release; x = 1 after that edge.
- Line timing: run one line.
  - hsync falls when x = 656 and rises when x = 752.
  - video_on falls when x = 640.
  - x wraps 799 -> 0 with y incrementing 0 -> 1.
- Frame timing: run a full frame.
  - vsync low only for y = 490..491.
  - video_on = 0 for all y >= 480.
  - frame_start pulses once, 840000 clks after the previous wrap.
- Reset mid-operation: assert reset_n = 0 at x = 700, y = 300 for 1 clk.
  - Next edge: x = y = 0, hsync = vsync = 1, div_count = 0.
- Simultaneous wrap: at x = 799, y = 524 with p_tick = 1.
  - Next edge: x = y = 0, frame_start = 1 for exactly 1 clk.
  - With VGA_SYNC_FRAME_CNT_EN defined: frame_count increments, 255 -> 0 checked after 256 frames (forced by shrunk parameters).
- Parameter override: CLK_DIV = 1, small H/V values (H: 8,2,2,2; V: 4,1,1,1).
  - Verify all wrap points, sync windows and video_on against a reference model.
